// File: rtl/zoran_send_pkg.sv
// Shared types and constants for the Nios send scheduler: FSM states, sources,
// Avalon register addresses and STATUS bit positions.
package zoran_send_pkg;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    typedef enum logic {
        SRC_NIOS,
        SRC_HW
    } src_t;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;
    localparam logic [1:0] ADDR_SENT    = 2'd3;

    localparam int ST_FULL  = 8;
    localparam int ST_EMPTY = 9;
    localparam int ST_BUSY  = 10;
    localparam int ST_OVF   = 11;
    localparam int ST_TO    = 12;

endpackage

// File: rtl/zoran_nios_send_ctrl_if.sv
// Bus bundle for the send scheduler: Avalon-MM slave port, hardware
// requester sideband and the downstream valid/ack output.
interface zoran_nios_send_ctrl_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        hw_req;
    logic [31:0] hw_data;
    logic        hw_grant;
    logic [31:0] out_port;
    logic        out_valid;
    logic        out_ack;

    modport master (
        output address, chipselect, write_n, writedata, hw_req, hw_data, out_ack,
        input  readdata, hw_grant, out_port, out_valid
    );

    modport slave (
        input  address, chipselect, write_n, writedata, hw_req, hw_data, out_ack,
        output readdata, hw_grant, out_port, out_valid
    );

endinterface

// File: rtl/zoran_send_fifo.sv
// FIFO_DEPTH x 32 synchronous FIFO holding Nios words; flush overrides any
// same-cycle push or pop. Depth must be a power of two.
module zoran_send_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    input  logic        flush,
    output logic [31:0] pop_data,
    output logic [7:0]  level,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [31:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;
    assign pop_data = mem[rd_ptr];
    assign level    = 8'(count);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/zoran_nios_send_ctrl.sv
// Send scheduler sharing out_port between the Nios FIFO and a hardware
// requester, with round-robin arbitration, valid/ack handshake and timeout.
//
// state | meaning
// IDLE  | no word on out_port; load the next word when enabled and a source is ready
// SEND  | out_valid high; waiting for out_ack or for the timeout to expire
module zoran_nios_send_ctrl
    import zoran_send_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input logic               clk,
    input logic               reset_n,
    zoran_nios_send_ctrl_if.slave bus
);

    localparam logic [15:0] TIMER_LOAD = 16'(TIMEOUT - 1);

    state_t      state;
    src_t        last_src;
    logic [15:0] timer;
    logic [31:0] out_port_q;
    logic        out_valid_q;
    logic        enable;
    logic        ovf;
    logic        to;
    logic [31:0] sent_cnt;

    logic        wr_en;
    logic        wr_data;
    logic        wr_status;
    logic        wr_ctrl;
    logic        wr_sent;
    logic        flush;
    logic        nios_rdy;
    logic        load;
    logic        pick_hw;
    logic        ack_done;
    logic        timeout_hit;

    logic [31:0] fifo_data;
    logic [7:0]  fifo_level;
    logic        fifo_full;
    logic        fifo_empty;

    assign wr_en     = bus.chipselect & ~bus.write_n;
    assign wr_data   = wr_en & (bus.address == ADDR_DATA);
    assign wr_status = wr_en & (bus.address == ADDR_STATUS);
    assign wr_ctrl   = wr_en & (bus.address == ADDR_CONTROL);
    assign wr_sent   = wr_en & (bus.address == ADDR_SENT);
    assign flush     = wr_ctrl & bus.writedata[1];

    // Round-robin: on a tie, serve whichever source did not go last.
    assign nios_rdy    = ~fifo_empty;
    assign load        = (state == IDLE) & enable & (nios_rdy | bus.hw_req);
    assign pick_hw     = bus.hw_req & (~nios_rdy | (last_src == SRC_NIOS));
    assign bus.hw_grant = load & pick_hw;

    assign ack_done    = (state == SEND) & bus.out_ack;
    assign timeout_hit = (state == SEND) & ~bus.out_ack & (timer == '0);

    assign bus.out_port  = out_port_q;
    assign bus.out_valid = out_valid_q;

    zoran_send_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (wr_data),
        .push_data (bus.writedata),
        .pop       (load & ~pick_hw),
        .flush     (flush),
        .pop_data  (fifo_data),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            last_src    <= SRC_HW;
            timer       <= '0;
            out_port_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        out_port_q  <= pick_hw ? bus.hw_data : fifo_data;
                        out_valid_q <= 1'b1;
                        timer       <= TIMER_LOAD;
                        last_src    <= pick_hw ? SRC_HW : SRC_NIOS;
                        state       <= SEND;
                    end
                end
                SEND: begin
                    if (ack_done || timeout_hit) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky flags: a same-cycle set beats the write-1-to-clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable   <= 1'b0;
            ovf      <= 1'b0;
            to       <= 1'b0;
            sent_cnt <= '0;
        end else begin
            if (wr_ctrl) begin
                enable <= bus.writedata[0];
            end
            ovf <= (ovf & ~(wr_status & bus.writedata[ST_OVF])) | (wr_data & fifo_full);
            to  <= (to & ~(wr_status & bus.writedata[ST_TO])) | timeout_hit;
            if (wr_sent) begin
                sent_cnt <= '0;
            end else if (ack_done) begin
                sent_cnt <= sent_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_DATA:    bus.readdata = out_port_q;
            ADDR_STATUS: begin
                bus.readdata[7:0]      = fifo_level;
                bus.readdata[ST_FULL]  = fifo_full;
                bus.readdata[ST_EMPTY] = fifo_empty;
                bus.readdata[ST_BUSY]  = (state == SEND);
                bus.readdata[ST_OVF]   = ovf;
                bus.readdata[ST_TO]    = to;
            end
            ADDR_CONTROL: bus.readdata[0] = enable;
            ADDR_SENT:    bus.readdata = sent_cnt;
            default:      bus.readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_zoran_nios_send_ctrl.sv
// Directed bench for the send scheduler, FIFO_DEPTH=4 and TIMEOUT=8.
module tb_zoran_nios_send_ctrl;

    logic clk;
    logic reset_n;
    int   n_vec = 0;
    int   n_err = 0;
    int   sent_exp = 0;
    int   grant_cnt = 0;
    logic [31:0] rd;

    zoran_nios_send_ctrl_if bus_if ();

    zoran_nios_send_ctrl #(
        .FIFO_DEPTH(4),
        .TIMEOUT   (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus_if.hw_grant) grant_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic av_write(input logic [1:0] addr, input logic [31:0] data);
        bus_if.address    = addr;
        bus_if.writedata  = data;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        tick();
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
    endtask

    task automatic av_read(input logic [1:0] addr, output logic [31:0] data);
        bus_if.address    = addr;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b1;
        #1;
        data = bus_if.readdata;
        bus_if.chipselect = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] addr, input logic [31:0] exp);
        logic [31:0] v;
        av_read(addr, v);
        chk(tag, v, exp);
    endtask

    task automatic wait_valid(input string tag, output int waits);
        waits = 0;
        while (!bus_if.out_valid && waits < 20) begin
            tick();
            waits++;
        end
        chk({tag, "_valid"}, 32'(bus_if.out_valid), 32'd1);
    endtask

    task automatic send_ack(input string tag, input logic [31:0] exp_word,
                            input int exp_waits, input bit drop_hw);
        int waits;
        wait_valid(tag, waits);
        chk({tag, "_lat"}, 32'(waits), 32'(exp_waits));
        chk({tag, "_word"}, bus_if.out_port, exp_word);
        bus_if.out_ack = 1'b1;
        if (drop_hw) bus_if.hw_req = 1'b0;
        tick();
        bus_if.out_ack = 1'b0;
        sent_exp++;
    endtask

    initial begin
        int waits;
        int cnt;
        logic [31:0] words [5];

        reset_n           = 1'b0;
        bus_if.address    = '0;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.writedata  = '0;
        bus_if.hw_req     = 1'b0;
        bus_if.hw_data    = '0;
        bus_if.out_ack    = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset state
        chk("rst_valid", 32'(bus_if.out_valid), 32'd0);
        chk("rst_port", bus_if.out_port, 32'd0);
        chk("rst_grant", 32'(bus_if.hw_grant), 32'd0);
        rd_chk("rst_data", 2'd0, 32'h0);
        rd_chk("rst_status", 2'd1, 32'h200);
        rd_chk("rst_ctrl", 2'd2, 32'h0);
        rd_chk("rst_sent", 2'd3, 32'h0);

        // Round-robin: two Nios words plus a persistent hw_req
        av_write(2'd0, 32'h1111_0001);
        av_write(2'd0, 32'h1111_0002);
        bus_if.hw_data = 32'h1234_5678;
        bus_if.hw_req  = 1'b1;
        grant_cnt      = 0;
        tick();
        tick();
        chk("rr_no_grant_disabled", 32'(grant_cnt), 32'd0);
        chk("rr_idle_disabled", 32'(bus_if.out_valid), 32'd0);
        av_write(2'd2, 32'h1);
        send_ack("rr_n1", 32'h1111_0001, 1, 1'b0);
        send_ack("rr_h1", 32'h1234_5678, 1, 1'b0);
        send_ack("rr_n2", 32'h1111_0002, 1, 1'b0);
        send_ack("rr_h2", 32'h1234_5678, 1, 1'b1);
        repeat (3) tick();
        chk("rr_grants", 32'(grant_cnt), 32'd2);
        chk("rr_quiet", 32'(bus_if.out_valid), 32'd0);
        rd_chk("rr_sent", 2'd3, 32'(sent_exp));

        // Single Nios word, latency and SENT clear
        av_write(2'd3, 32'hDEAD_BEEF);
        sent_exp = 0;
        rd_chk("sent_clear", 2'd3, 32'h0);
        av_write(2'd0, 32'hA5A5_0001);
        chk("one_not_yet", 32'(bus_if.out_valid), 32'd0);
        send_ack("one", 32'hA5A5_0001, 1, 1'b0);
        chk("one_drop", 32'(bus_if.out_valid), 32'd0);
        rd_chk("one_sent", 2'd3, 32'd1);
        rd_chk("one_status", 2'd1, 32'h200);

        // Overflow while disabled, then drain in order at 2 cycles/word
        av_write(2'd2, 32'h0);
        for (int i = 0; i < 5; i++) begin
            words[i] = 32'hB000_0001 + 32'(i);
            av_write(2'd0, words[i]);
        end
        rd_chk("ovf_status", 2'd1, 32'h904);
        av_write(2'd2, 32'h1);
        for (int i = 0; i < 4; i++) begin
            send_ack($sformatf("ovf_w%0d", i + 1), words[i], 1, 1'b0);
        end
        repeat (3) tick();
        chk("ovf_w5_lost", 32'(bus_if.out_valid), 32'd0);
        rd_chk("ovf_after", 2'd1, 32'hA00);
        av_write(2'd1, 32'h800);
        rd_chk("ovf_w1c", 2'd1, 32'h200);
        rd_chk("ovf_sent", 2'd3, 32'(sent_exp));

        // Timeout with out_ack held low
        av_write(2'd0, 32'hC0DE_0004);
        wait_valid("to", waits);
        cnt = 0;
        while (bus_if.out_valid && cnt < 50) begin
            cnt++;
            tick();
        end
        chk("to_cycles", 32'(cnt), 32'd8);
        rd_chk("to_status", 2'd1, 32'h1200);
        rd_chk("to_sent", 2'd3, 32'(sent_exp));
        av_write(2'd1, 32'h1000);
        rd_chk("to_w1c", 2'd1, 32'h200);

        // Flush while a word is in flight
        av_write(2'd2, 32'h0);
        for (int i = 0; i < 4; i++) av_write(2'd0, 32'hD000_0001 + 32'(i));
        av_write(2'd2, 32'h1);
        wait_valid("fl", waits);
        chk("fl_word", bus_if.out_port, 32'hD000_0001);
        rd_chk("fl_pre", 2'd1, 32'h403);
        av_write(2'd2, 32'h3);
        rd_chk("fl_post", 2'd1, 32'h600);
        chk("fl_inflight", 32'(bus_if.out_valid), 32'd1);
        bus_if.out_ack = 1'b1;
        tick();
        bus_if.out_ack = 1'b0;
        sent_exp++;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus_if.out_valid) cnt++;
            tick();
        end
        chk("fl_no_more", 32'(cnt), 32'd0);
        rd_chk("fl_sent", 2'd3, 32'(sent_exp));
        rd_chk("fl_ctrl", 2'd2, 32'h1);

        // Asynchronous reset in the middle of SEND
        av_write(2'd0, 32'hE000_0006);
        wait_valid("ar", waits);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_valid", 32'(bus_if.out_valid), 32'd0);
        rd_chk("ar_data", 2'd0, 32'h0);
        rd_chk("ar_status", 2'd1, 32'h200);
        rd_chk("ar_ctrl", 2'd2, 32'h0);
        rd_chk("ar_sent", 2'd3, 32'h0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        sent_exp = 0;
        av_write(2'd2, 32'h1);
        av_write(2'd0, 32'hF000_0007);
        send_ack("ar_post", 32'hF000_0007, 1, 1'b0);
        rd_chk("ar_post_sent", 2'd3, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/zoran_nios_send_ctrl.md
# zoran_nios_send_ctrl

Avalon-MM-controlled send scheduler for the Zoran Nios output data path. It shares one 32-bit `out_port` between two requesters:
- the Nios, which writes words into an internal FIFO;
- a hardware requester, which uses a req/grant sideband.

Each word is presented downstream with a valid/ack handshake and a timeout. It replaces a bare output PIO where software needs flow control and a second producer must reach the same port.

## Interface
Parameters:
- FIFO_DEPTH, 4, Nios word FIFO depth; power of two, 2..16
- TIMEOUT, 255, SEND cycles without ack before the word is dropped; 1..65535

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low; one clock; all state cleared on assertion
- address  in  2  Avalon register select
- chipselect  in  1  Avalon select
- write_n  in  1  Avalon write strobe, active-low
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data, combinational from address, zero wait states
- hw_req  in  1  hardware requester wants to send hw_data
- hw_data  in  32  hardware word, sampled in the grant cycle
- hw_grant  out  1  one-cycle pulse: hw_data captured this cycle
- out_port  out  32  word to consumer; holds last sent word
- out_valid  out  1  out_port valid, held until ack or timeout
- out_ack  in  1  consumer accepts (sampled while out_valid=1)

## Operation
Register map (write = chipselect & ~write_n; reads have no side effects):
- 0 DATA
  - W: push writedata; if FIFO full (evaluated before any same-cycle pop), drop it and set OVF.
  - R: current out_port.
- 1 STATUS
  - R: [7:0] FIFO level, [8] full, [9] empty, [10] busy (state==SEND), [11] OVF, [12] TO.
  - W: write-1-to-clear bits 11, 12.
- 2 CONTROL
  - W: [0] enable (reset 0); [1] flush, self-clearing, empties FIFO.
  - R: {31'b0, enable}.
- 3 SENT
  - R: 32-bit count of acked words, wraps 0xFFFFFFFF->0.
  - W: any value clears it to 0.

FSM (reset: IDLE):
- IDLE: if enable and (FIFO non-empty or hw_req), arbitrate and load, then go to SEND.
  - Only one source ready: serve it.
  - Both ready: serve the source not served last (round-robin; last_src resets to HW, so Nios wins the first tie).
  - Load: out_port<=word, out_valid<=1, timer<=0.
  - Nios word: FIFO pop in the load cycle.
  - HW word: hw_grant=1 in the load cycle.
- SEND, out_ack=1: out_valid<=0, SENT+=1, go to IDLE.
- SEND, timer==TIMEOUT-1 without ack: out_valid<=0, set TO, word discarded, go to IDLE.
- SEND, otherwise: timer+=1.

Boundary rules:
- Enable cleared in SEND: the in-flight word completes or times out; no new load follows.
- Flush in SEND: FIFO emptied; in-flight word unaffected.
- Flush and DATA write in the same cycle cannot occur (different addresses).
- Push on the pop cycle with the FIFO not full: both take effect; level unchanged.
- A hw_req drop before grant is legal: no grant, nothing latched.
- SENT increment and SENT clear in the same cycle: clear wins.
- W1C and a set of the same sticky bit in the same cycle: set wins.

## Timing
- Reset values:
  - outputs: out_port=0, out_valid=0, hw_grant=0, readdata by address (0 except STATUS[9]=1);
  - state: FIFO empty, enable=0, OVF=TO=0, SENT=0, last_src=HW.
- A Nios write at edge T, with an empty FIFO, IDLE and enable=1, gives out_valid=1 after edge T+1.
- Back-to-back throughput: 2 cycles/word when ack is given in the first SEND cycle (IDLE, SEND).
- hw_grant is high exactly in the IDLE cycle whose closing edge loads hw_data.
- Timeout: out_valid high for exactly TIMEOUT cycles, then low.
- Reset asserted mid-SEND: out_valid drops immediately (asynchronous); no SENT increment.

## Structure
- Package zoran_send_pkg:
  - state enum {IDLE, SEND};
  - register address constants DATA/STATUS/CONTROL/SENT;
  - STATUS bit index constants;
  - source enum {SRC_NIOS, SRC_HW}.
- Sub-module zoran_send_fifo:
  - parameterised FIFO_DEPTH×32 synchronous FIFO;
  - push/pop/flush inputs; level/full/empty outputs.
- Top-level holds the register file, arbiter, FSM and timeout counter.

## Test plan
- Enable=1, write 0xA5A5_0001; ack 1 cycle after valid -> out_port=0xA5A5_0001, out_valid 1 cycle after write, SENT=1, FIFO empty.
- Enable=0, write 5 words with FIFO_DEPTH=4 -> level=4, full=1, OVF=1, 5th word lost; enable -> words 1-4 emitted in order.
- hw_req held high and FIFO holding 2 words, ack every valid -> order NIOS, HW, NIOS, HW; one hw_grant pulse per HW word; hw_data 0x1234_5678 appears on out_port.
- out_ack tied 0, TIMEOUT=8 -> out_valid high exactly 8 cycles; TO=1; SENT unchanged; writing 0x1000 to STATUS clears TO.
- FIFO holding 3 words, word in SEND: write CONTROL flush -> in-flight word acks normally, level=0, no further valid.
- Reset asserted mid-SEND -> out_valid=0 immediately; all registers at reset values; first post-reset write is emitted normally.
